// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serialiser.
// Single clock domain; synchronous active-low reset.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       uart_tx_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             push, pop, bit_done, fifo_empty;

    assign ready_o    = (count_q != OCC_FULL);
    assign push       = valid_i && ready_o;
    assign fifo_empty = (count_q == '0);
    assign bit_done   = (baud_q == BAUD_LAST);
    assign busy_o     = busy_q;
    assign uart_tx_o  = tx_q;

    // The line level for the next bit is decided here so uart_tx_o comes straight from a flop.
    always_comb begin
        pop       = 1'b0;
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    // Storage is not cleared on reset; flushing the pointers and count empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances at 868, 16 and 2 clocks per bit
// share one clock and are exercised one scenario at a time.
module tb_uart_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int num_checks = 0;
    int num_fail   = 0;

    logic       rst_a, valid_a, ready_a, busy_a, tx_a;
    logic       rst_b, valid_b, ready_b, busy_b, tx_b;
    logic       rst_c, valid_c, ready_c, busy_c, tx_c;
    logic [7:0] data_a, data_b, data_c;

    uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(4), .CNT_W(10)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .data_i(data_a), .valid_i(valid_a),
        .ready_o(ready_a), .busy_o(busy_a), .uart_tx_o(tx_a));

    uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .data_i(data_b), .valid_i(valid_b),
        .ready_o(ready_b), .busy_o(busy_b), .uart_tx_o(tx_b));

    uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .CNT_W(1)) dut_c (
        .clk_i(clk), .rst_i(rst_c), .data_i(data_c), .valid_i(valid_c),
        .ready_o(ready_c), .busy_o(busy_c), .uart_tx_o(tx_c));

    function automatic logic line_of(input int sel);
        case (sel)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return ready_a;
            1:       return ready_b;
            default: return ready_c;
        endcase
    endfunction

    task automatic drive(input int sel, input logic r, input logic v, input logic [7:0] d);
        case (sel)
            0: begin rst_a = r; valid_a = v; data_a = d; end
            1: begin rst_b = r; valid_b = v; data_b = d; end
            default: begin rst_c = r; valid_c = v; data_c = d; end
        endcase
    endtask

    task automatic put_byte(input int sel, input logic [7:0] d);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, d);
        @(posedge clk);
        #1 drive(sel, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic reset_dut(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 drive(sel, 1'b1, 1'b0, 8'h00);
    endtask

    // Leaves the caller just after the edge on which the line fell.
    task automatic wait_start(input int sel, input int max_cycles, output logic found);
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (line_of(sel) === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Samples every cycle of one frame; bits[i] is the first sample of bit i.
    task automatic sample_frame(input int sel, input int cpb, output logic [9:0] bits,
                                output int glitches, output int busy_lows);
        logic v;
        bits      = '0;
        glitches  = 0;
        busy_lows = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < cpb; k++) begin
                @(negedge clk);
                v = line_of(sel);
                if (k == 0) bits[b] = v;
                else if (v !== bits[b]) glitches++;
                if (busy_of(sel) !== 1'b1) busy_lows++;
            end
        end
    endtask

    // Mid-bit sampling receiver used as the loopback partner.
    task automatic rx_byte(input int sel, input int cpb, output logic [7:0] b,
                           output logic start_ok, output logic stop_ok, output logic found);
        b        = 8'h00;
        start_ok = 1'b0;
        stop_ok  = 1'b0;
        wait_start(sel, 40 * cpb, found);
        if (found) begin
            repeat (cpb / 2) @(negedge clk);
            start_ok = (line_of(sel) === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (cpb) @(negedge clk);
                b[i] = line_of(sel);
            end
            repeat (cpb) @(negedge clk);
            stop_ok = (line_of(sel) === 1'b1);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            num_checks++;
            if (line_of(s) !== 1'b1) begin
                num_fail++;
                $display("[TB] FAIL reset_tx dut%0d: got %b expected 1", s, line_of(s));
            end
            num_checks++;
            if (busy_of(s) !== 1'b0) begin
                num_fail++;
                $display("[TB] FAIL reset_busy dut%0d: got %b expected 0", s, busy_of(s));
            end
            num_checks++;
            if (ready_of(s) !== 1'b1) begin
                num_fail++;
                $display("[TB] FAIL reset_ready dut%0d: got %b expected 1", s, ready_of(s));
            end
        end
        #1;
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_single_frame();
        logic [9:0] bits;
        int gl, bl;
        reset_dut(0);
        put_byte(0, 8'h55);
        @(negedge clk);
        num_checks++;
        if (tx_a !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL single_pre_pop_tx: got %b expected 1", tx_a);
        end
        sample_frame(0, 868, bits, gl, bl);
        num_checks++;
        if (bits !== 10'b1_0101_0101_0) begin
            num_fail++;
            $display("[TB] FAIL single_bits: got %b expected %b", bits, 10'b1_0101_0101_0);
        end
        num_checks++;
        if (gl !== 0) begin
            num_fail++;
            $display("[TB] FAIL single_glitch: got %0d expected 0", gl);
        end
        num_checks++;
        if (bl !== 0) begin
            num_fail++;
            $display("[TB] FAIL single_busy_during: got %0d low samples expected 0", bl);
        end
        @(negedge clk);
        num_checks++;
        if (busy_a !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL single_busy_after: got %b expected 0", busy_a);
        end
        num_checks++;
        if (tx_a !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL single_tx_after: got %b expected 1", tx_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits0, bits1;
        int gl0, gl1, bl0, bl1;
        reset_dut(1);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 8'hA5);
        @(posedge clk);
        #1 drive(1, 1'b1, 1'b1, 8'h3C);
        @(posedge clk);
        #1 drive(1, 1'b1, 1'b0, 8'h00);
        sample_frame(1, 16, bits0, gl0, bl0);
        sample_frame(1, 16, bits1, gl1, bl1);
        num_checks++;
        if (bits0 !== {1'b1, 8'hA5, 1'b0}) begin
            num_fail++;
            $display("[TB] FAIL b2b_first_bits: got %b expected %b", bits0, {1'b1, 8'hA5, 1'b0});
        end
        num_checks++;
        if (bits1 !== {1'b1, 8'h3C, 1'b0}) begin
            num_fail++;
            $display("[TB] FAIL b2b_second_bits: got %b expected %b", bits1, {1'b1, 8'h3C, 1'b0});
        end
        num_checks++;
        if ((gl0 + gl1) !== 0) begin
            num_fail++;
            $display("[TB] FAIL b2b_glitch: got %0d expected 0", gl0 + gl1);
        end
        num_checks++;
        if ((bl0 + bl1) !== 0) begin
            num_fail++;
            $display("[TB] FAIL b2b_busy_during: got %0d expected 0", bl0 + bl1);
        end
        @(negedge clk);
        num_checks++;
        if (busy_b !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL b2b_busy_after: got %b expected 0", busy_b);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] vec [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int accept_cyc [6];
        int idx, cyc;
        logic r, found;
        logic [9:0] bits;
        int gl, bl;
        reset_dut(1);
        idx = 0;
        cyc = 0;
        fork
            begin
                @(negedge clk);
                drive(1, 1'b1, 1'b1, vec[0]);
                while (idx < 6 && cyc < 2000) begin
                    r = ready_b;
                    @(posedge clk);
                    cyc++;
                    if (r) begin
                        accept_cyc[idx] = cyc;
                        idx++;
                    end
                    #1;
                    if (idx < 6) drive(1, 1'b1, 1'b1, vec[idx]);
                    else drive(1, 1'b1, 1'b0, 8'h00);
                    @(negedge clk);
                    if (idx == 5 && cyc == 5) begin
                        num_checks++;
                        if (ready_b !== 1'b0) begin
                            num_fail++;
                            $display("[TB] FAIL full_ready: got %b expected 0", ready_b);
                        end
                    end
                end
                num_checks++;
                if (idx !== 6 || accept_cyc[4] !== 5) begin
                    num_fail++;
                    $display("[TB] FAIL full_fill_timing: got %0d accepts, 5th at %0d expected 6 accepts, 5th at 5",
                             idx, accept_cyc[4]);
                end
                num_checks++;
                if (accept_cyc[5] !== 163) begin
                    num_fail++;
                    $display("[TB] FAIL full_sixth_accept: got cycle %0d expected 163", accept_cyc[5]);
                end
            end
            begin
                wait_start(1, 100, found);
                num_checks++;
                if (found !== 1'b1) begin
                    num_fail++;
                    $display("[TB] FAIL full_start_timeout: got %b expected 1", found);
                end
                if (found) begin
                    for (int i = 0; i < 6; i++) begin
                        sample_frame(1, 16, bits, gl, bl);
                        num_checks++;
                        if (bits !== {1'b1, vec[i], 1'b0}) begin
                            num_fail++;
                            $display("[TB] FAIL full_frame%0d: got %b expected %b", i, bits, {1'b1, vec[i], 1'b0});
                        end
                        num_checks++;
                        if (gl !== 0) begin
                            num_fail++;
                            $display("[TB] FAIL full_glitch%0d: got %0d expected 0", i, gl);
                        end
                    end
                end
            end
        join
        @(negedge clk);
        num_checks++;
        if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL full_drained: got busy=%b tx=%b expected busy=0 tx=1", busy_b, tx_b);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        reset_dut(0);
        put_byte(0, 8'h55);
        put_byte(0, 8'h0F);
        repeat (4 * 868 + 434) @(negedge clk);
        num_checks++;
        if (tx_a !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL mid_bit3_level: got %b expected 0", tx_a);
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1 drive(0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        num_checks++;
        if (tx_a !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL mid_reset_tx: got %b expected 1", tx_a);
        end
        num_checks++;
        if (busy_a !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy_a);
        end
        num_checks++;
        if (ready_a !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL mid_reset_ready: got %b expected 1", ready_a);
        end
        bad = 0;
        for (int i = 0; i < 10 * 868 + 20; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        num_checks++;
        if (bad !== 0) begin
            num_fail++;
            $display("[TB] FAIL mid_no_further_frames: got %0d active samples expected 0", bad);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_vec [3] = '{8'h55, 8'h00, 8'hFF};
        logic [7:0] got;
        logic s_ok, p_ok, found;
        reset_dut(1);
        fork
            begin
                put_byte(1, exp_vec[0]);
                put_byte(1, exp_vec[1]);
                put_byte(1, exp_vec[2]);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    rx_byte(1, 16, got, s_ok, p_ok, found);
                    num_checks++;
                    if (found !== 1'b1) begin
                        num_fail++;
                        $display("[TB] FAIL loop_found%0d: got %b expected 1", i, found);
                    end
                    num_checks++;
                    if (got !== exp_vec[i]) begin
                        num_fail++;
                        $display("[TB] FAIL loop_byte%0d: got %h expected %h", i, got, exp_vec[i]);
                    end
                    num_checks++;
                    if (s_ok !== 1'b1) begin
                        num_fail++;
                        $display("[TB] FAIL loop_start%0d: got %b expected 1", i, s_ok);
                    end
                    num_checks++;
                    if (p_ok !== 1'b1) begin
                        num_fail++;
                        $display("[TB] FAIL loop_stop%0d: got %b expected 1", i, p_ok);
                    end
                end
            end
        join
    endtask

    task automatic test_min_baud();
        logic [9:0] bits;
        int gl, bl;
        reset_dut(2);
        put_byte(2, 8'h81);
        @(negedge clk);
        num_checks++;
        if (tx_c !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL min_pre_pop_tx: got %b expected 1", tx_c);
        end
        sample_frame(2, 2, bits, gl, bl);
        num_checks++;
        if (bits !== 10'b11_0000_0010) begin
            num_fail++;
            $display("[TB] FAIL min_bits: got %b expected %b", bits, 10'b11_0000_0010);
        end
        num_checks++;
        if (gl !== 0 || bl !== 0) begin
            num_fail++;
            $display("[TB] FAIL min_glitch_busy: got glitches=%0d busy_lows=%0d expected 0/0", gl, bl);
        end
        @(negedge clk);
        num_checks++;
        if (busy_c !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL min_busy_after: got %b expected 0", busy_c);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_loopback();
        test_min_baud();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end
endmodule
